csr_commit_ctrl: RTL

Write-back-stage commit controller: the initiator side of the CSR register file's access port. Accepts one instruction per cycle from MEM over a valid/allowin handshake and drives the CSR file's signals: write port (`csr_we/num/wmask/wvalue`), read address, exception-commit signals (`wb_ex/ecode/esubcode/pc/badvaddr`) and `ertn_flush`. Turns committed exceptions, interrupts and `ertn` into a registered pipeline flush with a redirect PC for IF.

---
 rtl/csr_commit_pkg.sv | 31 +++
 rtl/csr_commit_ctrl_flush_fsm.sv | 51 +++++
 rtl/csr_commit_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/csr_commit_pkg.sv
// csr_commit_pkg: op encodings, exception codes, flush FSM states and the WB stage record
package csr_commit_pkg;
  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_CSRRD   = 3'd1;
  localparam logic [2:0] OP_CSRWR   = 3'd2;
  localparam logic [2:0] OP_CSRXCHG = 3'd3;
  localparam logic [2:0] OP_ERTN    = 3'd4;
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} flush_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [13:0] csr_num;
    logic [31:0] rj_value;
    logic [31:0] rd_value;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] badvaddr;
  } ws_bus_t;
  function automatic logic is_csr_op(input logic [2:0] op);
    return op == OP_CSRRD || op == OP_CSRWR || op == OP_CSRXCHG;
  endfunction
endpackage

// File: rtl/csr_commit_ctrl_flush_fsm.sv
// csr_flush_fsm: RUN/FLUSH/DRAIN sequencer; registers the redirect PC and kills WB during flush/drain
module csr_flush_fsm
  import csr_commit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_req,
  input  logic [31:0] flush_target,
  output logic        ws_flush,
  output logic [31:0] ws_flush_pc,
  output logic        ws_kill
);
  flush_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      RUN: begin
        state_d = flush_req ? FLUSH : RUN;
        pc_d    = flush_req ? flush_target : pc_q;
      end
      FLUSH: begin
        state_d = DRAIN;
        cnt_d   = 3'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        state_d = cnt_q == 3'd0 ? RUN : DRAIN;
        cnt_d   = cnt_q == 3'd0 ? cnt_q : cnt_q - 3'd1;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  assign ws_flush    = state_q == FLUSH;
  assign ws_flush_pc = pc_q;
  assign ws_kill     = state_q != RUN;
endmodule

// File: rtl/csr_commit_ctrl.sv
// csr_commit_ctrl: WB-stage commit controller driving the CSR file port and the pipeline flush.
// Optional CSR_COMMIT_CNT_EN adds exc_cnt/ertn_cnt commit counters.
module csr_commit_ctrl
  import csr_commit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [2:0]  ms_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_rj_value,
  input  logic [31:0] ms_rd_value,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic [31:0] ms_badvaddr,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic [13:0] csr_raddr,
  input  logic [31:0] csr_rvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic        ertn_flush,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ex_exit,
  input  logic        csr_has_int,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_flush,
  output logic [31:0] ws_flush_pc
`ifdef CSR_COMMIT_CNT_EN
  ,
  output logic [31:0] exc_cnt,
  output logic [31:0] ertn_cnt
`endif
);
  ws_bus_t     ws_q, ws_d;
  logic        ws_valid_q, ws_valid_d;
  logic        ws_kill, active, is_int, is_exc, is_ertn, is_csr, is_none, flush_req;
  logic [31:0] flush_target;
  assign ws_allowin = 1'b1;
  // Younger instructions arriving alongside a flush-class commit are dropped as well
  always_comb begin
    ws_valid_d = ms_to_ws_valid && ws_allowin && !ws_kill && !flush_req;
    ws_d = ms_to_ws_valid && ws_allowin
      ? {ms_pc, ms_op, ms_csr_num, ms_rj_value, ms_rd_value, ms_dest, ms_result,
         ms_ex, ms_ecode, ms_esubcode, ms_badvaddr}
      : ws_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ws_valid_q <= 1'b0;
      ws_q       <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      ws_q       <= ws_d;
    end
  always_comb begin
    active       = ws_valid_q && !ws_kill;
    is_int       = active && csr_has_int;
    is_exc       = active && !csr_has_int && ws_q.ex;
    is_ertn      = active && !csr_has_int && !ws_q.ex && ws_q.op == OP_ERTN;
    is_csr       = active && !csr_has_int && !ws_q.ex && is_csr_op(ws_q.op);
    is_none      = active && !is_int && !is_exc && !is_ertn && !is_csr;
    flush_req    = is_int || is_exc || is_ertn;
    flush_target = is_ertn ? ex_exit : ex_entry;
    wb_ex        = is_int || is_exc;
    wb_ecode     = is_exc ? ws_q.ecode : ECODE_INT;
    wb_esubcode  = is_exc ? ws_q.esubcode : 9'd0;
    wb_pc        = wb_ex ? ws_q.pc : 32'd0;
    wb_badvaddr  = is_exc ? ws_q.badvaddr : 32'd0;
    ertn_flush   = is_ertn;
    csr_we       = is_csr && ws_q.op != OP_CSRRD;
    csr_num      = is_csr ? ws_q.csr_num : 14'd0;
    csr_raddr    = csr_num;
    csr_wmask    = !csr_we ? 32'd0 : ws_q.op == OP_CSRXCHG ? ws_q.rj_value : 32'hFFFF_FFFF;
    csr_wvalue   = csr_we ? ws_q.rd_value : 32'd0;
    rf_we        = (is_csr || is_none) && ws_q.dest != 5'd0;
    rf_waddr     = rf_we ? ws_q.dest : 5'd0;
    rf_wdata     = !rf_we ? 32'd0 : is_csr ? csr_rvalue : ws_q.result;
  end
  csr_flush_fsm #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .flush_req    (flush_req),
    .flush_target (flush_target),
    .ws_flush     (ws_flush),
    .ws_flush_pc  (ws_flush_pc),
    .ws_kill      (ws_kill)
  );
`ifdef CSR_COMMIT_CNT_EN
  logic [31:0] exc_cnt_q, exc_cnt_d, ertn_cnt_q, ertn_cnt_d;
  always_comb begin
    exc_cnt_d  = exc_cnt_q + (wb_ex ? 32'd1 : 32'd0);
    ertn_cnt_d = ertn_cnt_q + (ertn_flush ? 32'd1 : 32'd0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      exc_cnt_q  <= '0;
      ertn_cnt_q <= '0;
    end else begin
      exc_cnt_q  <= exc_cnt_d;
      ertn_cnt_q <= ertn_cnt_d;
    end
  assign exc_cnt  = exc_cnt_q;
  assign ertn_cnt = ertn_cnt_q;
`endif
endmodule
